// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 2-flop line synchroniser, mid-bit sampling on the
// oversampling tick, LSB-first shift-in, optional parity and stop-bit checks.
module uart_rx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int STOP_TICKS   = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int SMAX = (STOP_TICKS > OVERSAMPLING) ? STOP_TICKS : OVERSAMPLING;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLING - 1);
  localparam logic [SW-1:0] S_STOP = SW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
  localparam logic          P_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_rx_meta, r_rx_sync;
  logic [SW-1:0]          r_s, w_s_nxt;
  logic [NW-1:0]          r_n, w_n_nxt;
  logic [DATA_BITS-1:0]   r_shreg, w_shreg_nxt;
  logic                   r_pbit, w_pbit_nxt;
  logic [DATA_BITS-1:0]   r_data, w_data_nxt;
  logic                   r_frame_err, w_frame_err_nxt;
  logic                   r_parity_err, w_parity_err_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_armed, w_armed_nxt;
  logic                   w_rx;

  assign w_rx = r_rx_sync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_s          <= '0;
      r_n          <= '0;
      r_shreg      <= '0;
      r_pbit       <= 1'b0;
      r_data       <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_done       <= 1'b0;
      r_armed      <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_s          <= w_s_nxt;
      r_n          <= w_n_nxt;
      r_shreg      <= w_shreg_nxt;
      r_pbit       <= w_pbit_nxt;
      r_data       <= w_data_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_done       <= w_done_nxt;
      r_armed      <= w_armed_nxt;
    end
  end

  // r_armed blocks re-triggering after a frame whose stop bit was low (break):
  // the line must be seen high again before a new start edge is accepted.
  always_comb begin
    w_state_nxt      = r_state;
    w_s_nxt          = r_s;
    w_n_nxt          = r_n;
    w_shreg_nxt      = r_shreg;
    w_pbit_nxt       = r_pbit;
    w_data_nxt       = r_data;
    w_frame_err_nxt  = r_frame_err;
    w_parity_err_nxt = r_parity_err;
    w_done_nxt       = 1'b0;
    w_armed_nxt      = r_armed;
    case (r_state)
      ST_IDLE: begin
        if (w_rx) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_state_nxt = ST_START;
          w_s_nxt     = '0;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (r_s == S_HALF) begin
            w_s_nxt = '0;
            if (!w_rx) begin
              w_state_nxt = ST_DATA;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (r_s == S_BIT) begin
            w_s_nxt     = '0;
            w_shreg_nxt = {w_rx, r_shreg[DATA_BITS-1:1]};
            if (r_n == N_LAST) begin
              w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              w_n_nxt = r_n + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (i_tick) begin
          if (r_s == S_BIT) begin
            w_s_nxt     = '0;
            w_pbit_nxt  = w_rx;
            w_state_nxt = ST_STOP;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (i_tick) begin
          if (r_s == S_STOP) begin
            w_s_nxt          = '0;
            w_data_nxt       = r_shreg;
            w_frame_err_nxt  = ~w_rx;
            w_parity_err_nxt = (PARITY_EN != 0) ? (^r_shreg ^ r_pbit ^ P_ODD) : 1'b0;
            w_done_nxt       = 1'b1;
            w_armed_nxt      = w_rx;
            w_state_nxt      = ST_IDLE;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_data       = r_data;
  assign o_rx_done    = r_done;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance,
// table-driven frames plus hand-written glitch, break and reset sequences.
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 64;  // 16 ticks x 4 clk

  logic       clk;
  logic       reset_n;
  logic       tick;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       done_a, done_b, fe_a, fe_b, pe_a, pe_b, busy_a, busy_b;

  int vec_cnt     = 0;
  int miscompares = 0;

  int         cnt_a = 0, cnt_b = 0;
  logic [7:0] cap_data_a, cap_data_b;
  logic       cap_fe_a, cap_fe_b, cap_pe_a, cap_pe_b;
  logic       prev_a = 1'b0, prev_b = 1'b0;

  uart_rx_ctrl #(
    .DATA_BITS(8), .OVERSAMPLING(16), .STOP_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)
  ) u_dut_a (
    .i_clk(clk), .i_reset_n(reset_n), .i_tick(tick), .i_rx(rx_a),
    .o_data(data_a), .o_rx_done(done_a), .o_frame_err(fe_a),
    .o_parity_err(pe_a), .o_busy(busy_a)
  );

  uart_rx_ctrl #(
    .DATA_BITS(8), .OVERSAMPLING(16), .STOP_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_dut_b (
    .i_clk(clk), .i_reset_n(reset_n), .i_tick(tick), .i_rx(rx_b),
    .o_data(data_b), .o_rx_done(done_b), .o_frame_err(fe_b),
    .o_parity_err(pe_b), .o_busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int tcnt;
    tcnt = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt + 1) % 4;
      tick = (tcnt == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done_a) begin
        check("no_double_done_a", 32'(prev_a), 32'd0);
        cnt_a++;
        cap_data_a = data_a; cap_fe_a = fe_a; cap_pe_a = pe_a;
      end
      if (done_b) begin
        check("no_double_done_b", 32'(prev_b), 32'd0);
        cnt_b++;
        cap_data_b = data_b; cap_fe_b = fe_b; cap_pe_b = pe_b;
      end
      prev_a = done_a;
      prev_b = done_b;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input bit to_b, input logic v);
    if (to_b) rx_b = v;
    else      rx_a = v;
  endtask

  task automatic send_frame(input bit to_b, input logic [7:0] d, input logic pbit,
                            input logic stop, input int idle_bits);
    set_rx(to_b, 1'b0);
    wait_clks(BIT_CLKS);
    for (int unsigned i = 0; i < 8; i++) begin
      set_rx(to_b, d[i]);
      wait_clks(BIT_CLKS);
    end
    if (to_b) begin
      set_rx(to_b, pbit);
      wait_clks(BIT_CLKS);
    end
    set_rx(to_b, stop);
    wait_clks(BIT_CLKS);
    set_rx(to_b, 1'b1);
    wait_clks(BIT_CLKS * idle_bits);
  endtask

  typedef struct {
    bit         to_b;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    int         idle_bits;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int c0;
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 2, 8'h3C, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h81, 1'b0, 1'b1, 1, 8'h81, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b1, 1, 8'h07, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h07, 1'b0, 1'b1, 1, 8'h07, 1'b0, 1'b1};

    reset_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    wait_clks(5);
    check("reset_data_a", 32'(data_a), 32'd0);
    check("reset_flags_a", {28'd0, done_a, fe_a, pe_a, busy_a}, 32'd0);
    check("reset_flags_b", {28'd0, done_b, fe_b, pe_b, busy_b}, 32'd0);
    reset_n = 1'b1;
    wait_clks(BIT_CLKS);

    for (int unsigned i = 0; i < 7; i++) begin
      c0 = vecs[i].to_b ? cnt_b : cnt_a;
      send_frame(vecs[i].to_b, vecs[i].data, vecs[i].pbit, vecs[i].stop, vecs[i].idle_bits);
      if (vecs[i].to_b) begin
        check($sformatf("v%0d_done_cnt", i), 32'(cnt_b - c0), 32'd1);
        check($sformatf("v%0d_data", i), 32'(cap_data_b), 32'(vecs[i].exp_data));
        check($sformatf("v%0d_frame_err", i), 32'(cap_fe_b), 32'(vecs[i].exp_fe));
        check($sformatf("v%0d_parity_err", i), 32'(cap_pe_b), 32'(vecs[i].exp_pe));
      end else begin
        check($sformatf("v%0d_done_cnt", i), 32'(cnt_a - c0), 32'd1);
        check($sformatf("v%0d_data", i), 32'(cap_data_a), 32'(vecs[i].exp_data));
        check($sformatf("v%0d_frame_err", i), 32'(cap_fe_a), 32'(vecs[i].exp_fe));
        check($sformatf("v%0d_parity_err", i), 32'(cap_pe_a), 32'(vecs[i].exp_pe));
      end
    end

    // glitch: 3 ticks low, start validation at mid-bit rejects it
    c0 = cnt_a;
    rx_a = 1'b0;
    wait_clks(8);
    check("glitch_busy_high", 32'(busy_a), 32'd1);
    wait_clks(4);
    rx_a = 1'b1;
    wait_clks(32);
    check("glitch_busy_low", 32'(busy_a), 32'd0);
    wait_clks(BIT_CLKS * 12);
    check("glitch_no_done", 32'(cnt_a - c0), 32'd0);
    check("glitch_data_held", 32'(data_a), 32'h81);

    // break: line held low yields one frame with framing error, then no repeats
    c0 = cnt_a;
    rx_a = 1'b0;
    wait_clks(BIT_CLKS * 10);
    check("break_done_cnt", 32'(cnt_a - c0), 32'd1);
    check("break_data", 32'(cap_data_a), 32'd0);
    check("break_frame_err", 32'(cap_fe_a), 32'd1);
    wait_clks(BIT_CLKS * 20);
    check("break_no_repeat", 32'(cnt_a - c0), 32'd1);
    check("break_idle", 32'(busy_a), 32'd0);
    rx_a = 1'b1;
    wait_clks(BIT_CLKS * 2);
    c0 = cnt_a;
    send_frame(1'b0, 8'hC3, 1'b0, 1'b1, 1);
    check("post_break_cnt", 32'(cnt_a - c0), 32'd1);
    check("post_break_data", 32'(cap_data_a), 32'hC3);
    check("post_break_frame_err", 32'(cap_fe_a), 32'd0);

    // reset in the middle of data bit 4 of 0x33
    c0 = cnt_a;
    rx_a = 1'b0;
    wait_clks(BIT_CLKS);
    for (int unsigned i = 0; i < 4; i++) begin
      rx_a = (i % 4 < 2) ? 1'b1 : 1'b0;
      wait_clks(BIT_CLKS);
    end
    rx_a = 1'b1;
    wait_clks(BIT_CLKS / 2);
    check("midframe_busy", 32'(busy_a), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_abort_busy", 32'(busy_a), 32'd0);
    check("reset_abort_data", 32'(data_a), 32'd0);
    check("reset_abort_flags", {29'd0, done_a, fe_a, pe_a}, 32'd0);
    rx_a = 1'b1;
    wait_clks(4);
    reset_n = 1'b1;
    wait_clks(BIT_CLKS * 8);
    check("reset_no_partial", 32'(cnt_a - c0), 32'd0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 1);
    check("post_reset_cnt", 32'(cnt_a - c0), 32'd1);
    check("post_reset_data", 32'(cap_data_a), 32'h5A);
    check("post_reset_errs", {30'd0, cap_fe_a, cap_pe_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
